// File: rtl/drive_next_pc_if.sv
// Sequencer <-> PC register / instruction memory bundle.
interface drive_next_pc_if #(
  parameter int PC_WIDTH  = 11,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic [PC_WIDTH-1:0]  PC;
  logic                 inst_valid;
  logic [1:0]           inst_op;
  logic [PC_WIDTH-1:0]  inst_target;
  logic [CNT_WIDTH-1:0] inst_count;
  logic                 update_pc;
  logic [PC_WIDTH-1:0]  next_PC;
  logic                 busy;
  logic                 done;

  // Environment side: issues start, returns PC and the decoded instruction.
  modport master (
    output start, PC, inst_valid, inst_op, inst_target, inst_count,
    input  update_pc, next_PC, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, PC, inst_valid, inst_op, inst_target, inst_count,
    output update_pc, next_PC, busy, done
  );
endinterface

// File: rtl/drive_next_pc.sv
// Next-PC sequencer: decodes the instruction at PC and drives update_pc/next_PC.
// Handles sequential advance, timed wait, a single-level counted loop and halt,
// plus one arming pulse because the PC register drops its first update after reset.
module drive_next_pc #(
  parameter int PC_WIDTH  = 11,
  parameter int CNT_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  drive_next_pc_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_NEXT = 2'd0;
  localparam logic [1:0] OP_WAIT = 2'd1;
  localparam logic [1:0] OP_LOOP = 2'd2;
  localparam logic [1:0] OP_HALT = 2'd3;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
  logic                 wait_act_q, wait_act_d;
  logic                 loop_act_q, loop_act_d;
  logic                 done_q, done_d;
  logic                 upd;
  logic [PC_WIDTH-1:0]  npc;
  logic [PC_WIDTH-1:0]  pc_inc;

  // Natural wrap at all-ones is intended.
  assign pc_inc = bus.PC + PC_WIDTH'(1);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      wait_act_q <= 1'b0;
      loop_cnt_q <= '0;
      loop_act_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wait_act_q <= wait_act_d;
      loop_cnt_q <= loop_cnt_d;
      loop_act_q <= loop_act_d;
      done_q     <= done_d;
    end
  end

  // Instruction decode, next-state and PC-update strobe.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wait_act_d = wait_act_q;
    loop_cnt_d = loop_cnt_q;
    loop_act_d = loop_act_q;
    done_d     = 1'b0;
    upd        = 1'b0;
    npc        = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_ARM;
          wait_cnt_d = '0;
          wait_act_d = 1'b0;
          loop_cnt_d = '0;
          loop_act_d = 1'b0;
        end
      end
      S_ARM: begin
        // Swallowed by the PC register; PC stays at its reset value.
        upd     = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.inst_valid) begin
          case (bus.inst_op)
            OP_NEXT: begin
              upd = 1'b1;
              npc = pc_inc;
            end
            OP_WAIT: begin
              if (!wait_act_q) begin
                if (bus.inst_count == '0) begin
                  upd = 1'b1;
                  npc = pc_inc;
                end else begin
                  wait_cnt_d = bus.inst_count;
                  wait_act_d = 1'b1;
                end
              end else if (wait_cnt_q == CNT_WIDTH'(1)) begin
                upd        = 1'b1;
                npc        = pc_inc;
                wait_act_d = 1'b0;
              end else begin
                wait_cnt_d = wait_cnt_q - CNT_WIDTH'(1);
              end
            end
            OP_LOOP: begin
              upd = 1'b1;
              if (!loop_act_q) begin
                if (bus.inst_count == '0) begin
                  npc = pc_inc;
                end else begin
                  loop_cnt_d = bus.inst_count - CNT_WIDTH'(1);
                  loop_act_d = 1'b1;
                  npc        = bus.inst_target;
                end
              end else if (loop_cnt_q == '0) begin
                loop_act_d = 1'b0;
                npc        = pc_inc;
              end else begin
                loop_cnt_d = loop_cnt_q - CNT_WIDTH'(1);
                npc        = bus.inst_target;
              end
            end
            default: begin  // HALT
              state_d    = S_DONE;
              done_d     = 1'b1;
              wait_act_d = 1'b0;
              loop_act_d = 1'b0;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.update_pc = upd;
  assign bus.next_PC   = npc;
  assign bus.busy      = (state_q == S_ARM) || (state_q == S_RUN);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_drive_next_pc.sv
// Bench: PC register + imem model around drive_next_pc, scoreboard of update/done events.
module tb_drive_next_pc;
  localparam int PW = 11;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  always #5 clk = ~clk;

  drive_next_pc_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();
  drive_next_pc #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Instruction memory, read asynchronously at PC.
  logic [1:0]    op_m  [2**PW];
  logic [PW-1:0] tgt_m [2**PW];
  logic [CW-1:0] cnt_m [2**PW];

  // PC register model: ignores its first update after reset.
  logic [PW-1:0] pc_q;
  logic          armed;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      armed <= 1'b0;
    end else if (bus.update_pc) begin
      if (!armed) armed <= 1'b1;
      else        pc_q  <= bus.next_PC;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.inst_valid  = !stall;
  assign bus.inst_op     = op_m[pc_q];
  assign bus.inst_target = tgt_m[pc_q];
  assign bus.inst_count  = cnt_m[pc_q];

  // Expected event: an update (next_PC) or a done pulse, and the cycles since the previous one.
  typedef struct packed {
    logic          is_done;
    logic [PW-1:0] npc;
    int            gap;    // 0 = don't care
  } ev_t;
  ev_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int gap   = 0;

  // Monitor: every update_pc or done pulse out of reset pops one expectation.
  always @(negedge clk) begin
    ev_t e;
    if (rst) gap = 0;
    else begin
      gap++;
      if (bus.update_pc || bus.done) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got upd=%0b done=%0b next_PC=%0d, required none",
                   bus.update_pc, bus.done, bus.next_PC);
        end else begin
          e = q.pop_front();
          if (e.is_done !== bus.done || e.npc !== bus.next_PC || (e.gap != 0 && e.gap != gap)) begin
            n_err++;
            $display("FAIL event: got done=%0b next_PC=%0d gap=%0d, required done=%0b next_PC=%0d gap=%0d",
                     bus.done, bus.next_PC, gap, e.is_done, e.npc, e.gap);
          end
        end
        gap = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input logic [PW-1:0] npc, input int g);
    q.push_back('{is_done: d, npc: npc, gap: g});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2**PW; i++) begin
      op_m[i] = 2'd3; tgt_m[i] = '0; cnt_m[i] = '0;
    end
  endtask

  task automatic set_inst(input int a, input logic [1:0] op, input logic [PW-1:0] t, input logic [CW-1:0] c);
    op_m[a] = op; tgt_m[a] = t; cnt_m[a] = c;
  endtask

  // Called just after a posedge; returns just after the posedge that enters ARM.
  task automatic reset_start();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_update_pc", {31'd0, bus.update_pc}, 32'd0);
    chk("rst_next_pc", {21'd0, bus.next_PC}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic start_only();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_queue_empty"}, q.size(), 32'd0);
    chk({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    chk({name, "_done_low"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic load_loop_prog();
    clear_mem();
    set_inst(0, 2'd0, 0, 0);
    set_inst(1, 2'd0, 0, 0);
    set_inst(2, 2'd0, 0, 0);
    set_inst(3, 2'd2, 11'd1, 8'd2);
    set_inst(4, 2'd3, 0, 0);
  endtask

  task automatic push_loop_trace();
    push(0, 0, 2);
    push(0, 1, 1); push(0, 2, 1); push(0, 3, 1);
    for (int k = 0; k < 2; k++) begin
      push(0, 1, 1); push(0, 2, 1); push(0, 3, 1);
    end
    push(0, 4, 1);
    push(1, 0, 2);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; stall = 1'b0;
    clear_mem();
    @(posedge clk); #1;

    // A: NEXT, WAIT 3, WAIT 0, HALT; a stray start while running is ignored.
    set_inst(0, 2'd0, 0, 0);
    set_inst(1, 2'd1, 0, 8'd3);
    set_inst(2, 2'd1, 0, 8'd0);
    set_inst(3, 2'd3, 0, 0);
    push(0, 0, 2); push(0, 1, 1); push(0, 2, 4); push(0, 3, 1); push(1, 0, 2);
    reset_start();
    chk("arm_busy", {31'd0, bus.busy}, 32'd1);
    repeat (2) @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("progA");

    // C: restart from DONE; LOOP to all-ones PC, NEXT wraps to 0.
    clear_mem();
    set_inst(0, 2'd2, 11'h7FF, 8'd1);
    set_inst(11'h7FF, 2'd0, 0, 0);
    set_inst(1, 2'd3, 0, 0);
    push(0, 0, 0); push(0, 11'h7FF, 1); push(0, 0, 1); push(0, 1, 1); push(1, 0, 2);
    start_only();
    wait_done("wrap");

    // B: counted loop, body 1..3 executed three times.
    load_loop_prog();
    push_loop_trace();
    reset_start();
    wait_done("loop");

    // D: WAIT 2 with two stalled cycles in the middle.
    clear_mem();
    set_inst(0, 2'd1, 0, 8'd2);
    set_inst(1, 2'd3, 0, 0);
    push(0, 0, 2); push(0, 1, 5); push(1, 0, 2);
    reset_start();
    repeat (3) @(posedge clk); #1;
    stall = 1'b1;
    repeat (2) @(posedge clk); #1;
    stall = 1'b0;
    wait_done("stall");

    // E: reset while the loop is active, then a clean rerun.
    load_loop_prog();
    push(0, 0, 2); push(0, 1, 1); push(0, 2, 1); push(0, 3, 1); push(0, 1, 1); push(0, 2, 1);
    reset_start();
    repeat (6) @(posedge clk); #1;
    chk("midloop_queue", q.size(), 32'd0);
    push_loop_trace();
    reset_start();
    wait_done("reloop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
